// File: rtl/dsramlike_axi_bridge_if.sv
// rtl/dsramlike_axi_bridge_if.sv - sram-like CPU data port plus single-beat AXI master channels
// The master modport is the bridge; the slave modport is the CPU/AXI environment around it.
interface dsramlike_axi_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output araddr, arsize, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready,
    output awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  araddr, arsize, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready,
    input  awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/dsramlike_axi_bridge.sv
// rtl/dsramlike_axi_bridge.sv - sram-like data port to AXI bridge, one single-beat transaction at a time
// Request fields are captured on acceptance so the CPU side may change them while AXI is in flight.
module dsramlike_axi_bridge (
  input  logic                         clk,
  input  logic                         rst,
  dsramlike_axi_bridge_if.master       bus
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        accept;
  logic        aw_hs;
  logic        w_hs;
  logic [2:0]  axsize;

  assign accept = (state_q == IDLE) && bus.data_req;
  assign aw_hs  = (state_q == WR_REQ) && !aw_done_q && bus.awready;
  assign w_hs   = (state_q == WR_REQ) && !w_done_q && bus.wready;
  assign axsize = (size_q == 2'b11) ? 3'b010 : {1'b0, size_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.data_req) state_d = bus.data_wr ? WR_REQ : RD_AR;
      RD_AR:   if (bus.arready)  state_d = RD_R;
      RD_R:    if (bus.rvalid)   state_d = IDLE;
      // AW and W may complete in either order; wait for both before the response
      WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_B;
      WR_B:    if (bus.bvalid)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    wr_d      = wr_q;
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    if (accept) begin
      addr_d  = bus.data_addr;
      wdata_d = bus.data_wdata;
      size_d  = bus.data_size;
      wr_d    = bus.data_wr;
    end
    if ((state_q == WR_REQ) && (state_d == WR_REQ)) begin
      aw_done_d = aw_done_q || aw_hs;
      w_done_d  = w_done_q || w_hs;
    end
  end

  always_comb begin
    bus.data_addr_ok = accept;
    bus.data_data_ok = wr_q ? ((state_q == WR_B) && bus.bvalid)
                            : ((state_q == RD_R) && bus.rvalid);
    bus.data_rdata   = ((state_q == RD_R) && bus.rvalid) ? bus.rdata : 32'h0;

    bus.araddr  = addr_q;
    bus.arsize  = axsize;
    bus.arvalid = (state_q == RD_AR);
    bus.rready  = (state_q == RD_R);

    bus.awaddr  = addr_q;
    bus.awsize  = axsize;
    bus.awvalid = (state_q == WR_REQ) && !aw_done_q;
    bus.wdata   = wdata_q;
    bus.wvalid  = (state_q == WR_REQ) && !w_done_q;
    bus.bready  = (state_q == WR_B);

    case (size_q)
      2'b00:   bus.wstrb = 4'b0001 << addr_q[1:0];
      2'b01:   bus.wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: bus.wstrb = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_dsramlike_axi_bridge.sv
// tb/tb_dsramlike_axi_bridge.sv - vector table plus scoreboard bench for dsramlike_axi_bridge
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dsramlike_axi_bridge;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [2:0]  exp_axsize;
    logic [3:0]  exp_wstrb;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   cur_vec = -1;
  vec_t vecs[10];
  sb_t  sb_q[$];

  dsramlike_axi_bridge_if bus ();

  dsramlike_axi_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (vec %0d, cyc %0d): got %h want %h", name, cur_vec, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic complete(input vec_t v, input int acc_cyc);
    sb_t e;
    chk("sb_nonempty", (sb_q.size() > 0), 1'b1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_wr", bus.data_wr === 1'bx ? 1'b0 : e.wr, v.wr);
      if (!e.wr) chk("data_rdata", bus.data_rdata, e.rdata);
    end
    if ((v.ar_dly + v.r_dly + v.aw_dly + v.w_dly + v.b_dly) == 0)
      chk("min_latency", cyc - acc_cyc, 2);
  endtask

  // Called 1ns after a rising edge with the bridge in IDLE
  task automatic do_txn(input vec_t v);
    int   acc_cyc;
    logic hs, aw_d, w_d;
    bus.data_req   = 1'b1;
    bus.data_wr    = v.wr;
    bus.data_size  = v.size;
    bus.data_addr  = v.addr;
    bus.data_wdata = v.wdata;
    @(negedge clk);
    chk("addr_ok_idle", bus.data_addr_ok, 1'b1);
    chk("data_ok_idle", bus.data_data_ok, 1'b0);
    chk("arvalid_idle", bus.arvalid, 1'b0);
    chk("rready_idle", bus.rready, 1'b0);
    chk("awvalid_idle", bus.awvalid, 1'b0);
    chk("wvalid_idle", bus.wvalid, 1'b0);
    chk("bready_idle", bus.bready, 1'b0);
    acc_cyc = cyc;
    sb_q.push_back('{v.wr, v.rdata});
    tick();
    bus.data_req   = 1'b0;
    bus.data_addr  = 32'hFFFF_FFFF;
    bus.data_wdata = ~v.wdata;
    bus.data_size  = ~v.size;
    if (!v.wr) begin
      hs = 1'b0;
      for (int c = 0; c < 64 && !hs; c++) begin
        bus.arready = (c >= v.ar_dly);
        @(negedge clk);
        chk("arvalid", bus.arvalid, 1'b1);
        chk("araddr", bus.araddr, v.addr);
        chk("arsize", bus.arsize, v.exp_axsize);
        chk("addr_ok_busy", bus.data_addr_ok, 1'b0);
        chk("data_ok_ar", bus.data_data_ok, 1'b0);
        if (bus.arvalid && bus.arready) hs = 1'b1;
        tick();
      end
      bus.arready = 1'b0;
      chk("ar_timeout", hs, 1'b1);
      hs = 1'b0;
      for (int c = 0; c < 64 && !hs; c++) begin
        bus.rvalid = (c >= v.r_dly);
        bus.rdata  = bus.rvalid ? v.rdata : 32'h5A5A_5A5A;
        @(negedge clk);
        chk("rready", bus.rready, 1'b1);
        chk("arvalid_r", bus.arvalid, 1'b0);
        chk("data_ok_r", bus.data_data_ok, bus.rvalid);
        chk("addr_ok_r", bus.data_addr_ok, 1'b0);
        if (bus.rvalid) begin
          complete(v, acc_cyc);
          hs = 1'b1;
        end else begin
          chk("rdata_zero", bus.data_rdata, 32'h0);
        end
        tick();
      end
      bus.rvalid = 1'b0;
      chk("r_timeout", hs, 1'b1);
    end else begin
      aw_d = 1'b0;
      w_d  = 1'b0;
      for (int c = 0; c < 64 && !(aw_d && w_d); c++) begin
        bus.awready = (c >= v.aw_dly) && !aw_d;
        bus.wready  = (c >= v.w_dly) && !w_d;
        @(negedge clk);
        chk("awvalid", bus.awvalid, !aw_d);
        chk("wvalid", bus.wvalid, !w_d);
        chk("bready_req", bus.bready, 1'b0);
        chk("data_ok_req", bus.data_data_ok, 1'b0);
        chk("addr_ok_req", bus.data_addr_ok, 1'b0);
        if (!aw_d) begin
          chk("awaddr", bus.awaddr, v.addr);
          chk("awsize", bus.awsize, v.exp_axsize);
        end
        if (!w_d) begin
          chk("wdata", bus.wdata, v.wdata);
          chk("wstrb", bus.wstrb, v.exp_wstrb);
        end
        if (bus.awvalid && bus.awready) aw_d = 1'b1;
        if (bus.wvalid && bus.wready) w_d = 1'b1;
        tick();
      end
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      chk("wr_req_timeout", aw_d && w_d, 1'b1);
      hs = 1'b0;
      for (int c = 0; c < 64 && !hs; c++) begin
        bus.bvalid = (c >= v.b_dly);
        @(negedge clk);
        chk("bready", bus.bready, 1'b1);
        chk("awvalid_b", bus.awvalid, 1'b0);
        chk("wvalid_b", bus.wvalid, 1'b0);
        chk("data_ok_b", bus.data_data_ok, bus.bvalid);
        chk("addr_ok_b", bus.data_addr_ok, 1'b0);
        if (bus.bvalid) begin
          complete(v, acc_cyc);
          hs = 1'b1;
        end
        tick();
      end
      bus.bvalid = 1'b0;
      chk("b_timeout", hs, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_ok, n_done, n_both, first_done, second_acc;

    //        wr    size   addr          wdata         rdata        ar r aw w b  axsize  wstrb
    vecs[0] = '{1'b0, 2'b10, 32'h1000_0004, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 0, 0, 3'b010, 4'b1111};
    vecs[1] = '{1'b0, 2'b00, 32'h2000_0001, 32'h0,        32'h0000_1200, 2, 3, 0, 0, 0, 3'b000, 4'b0010};
    vecs[2] = '{1'b0, 2'b11, 32'h3000_0008, 32'h0,        32'h8765_4321, 0, 1, 0, 0, 0, 3'b010, 4'b1111};
    vecs[3] = '{1'b1, 2'b00, 32'h4000_0003, 32'hAB00_0000, 32'h0,        0, 0, 3, 0, 1, 3'b000, 4'b1000};
    vecs[4] = '{1'b1, 2'b01, 32'h4000_0002, 32'h1234_0000, 32'h0,        0, 0, 0, 0, 0, 3'b001, 4'b1100};
    vecs[5] = '{1'b1, 2'b01, 32'h4000_0000, 32'h0000_5678, 32'h0,        0, 0, 0, 2, 0, 3'b001, 4'b0011};
    vecs[6] = '{1'b1, 2'b00, 32'h5000_0001, 32'h0000_CD00, 32'h0,        0, 0, 1, 1, 2, 3'b000, 4'b0010};
    vecs[7] = '{1'b1, 2'b11, 32'h6000_000C, 32'hCAFE_F00D, 32'h0,        0, 0, 2, 0, 0, 3'b010, 4'b1111};
    vecs[8] = '{1'b1, 2'b10, 32'h6000_0010, 32'h0BAD_CAFE, 32'h0,        0, 0, 0, 0, 3, 3'b010, 4'b1111};
    vecs[9] = '{1'b0, 2'b01, 32'h7000_0006, 32'h0,        32'h0000_BEEF, 10, 0, 0, 0, 0, 3'b001, 4'b1100};

    rst = 1'b1;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'b00;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    bus.arready = 1'b0; bus.rdata = 32'h0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_arvalid", bus.arvalid, 1'b0);
    chk("rst_rready", bus.rready, 1'b0);
    chk("rst_awvalid", bus.awvalid, 1'b0);
    chk("rst_wvalid", bus.wvalid, 1'b0);
    chk("rst_bready", bus.bready, 1'b0);
    chk("rst_data_ok", bus.data_data_ok, 1'b0);
    chk("rst_addr_ok", bus.data_addr_ok, 1'b0);
    chk("rst_rdata", bus.data_rdata, 32'h0);
    chk("rst_araddr", bus.araddr, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      cur_vec = i;
      do_txn(vecs[i]);
    end

    // Two reads with the request held high throughout
    cur_vec = 100;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'b10;
    bus.data_addr = 32'h7000_0000; bus.arready = 1'b1; bus.rvalid = 1'b1;
    bus.rdata = 32'h1111_2222;
    n_ok = 0; n_done = 0; n_both = 0; first_done = -1; second_acc = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.data_addr_ok) begin
        n_ok++;
        if (n_ok == 2) second_acc = cyc;
      end
      if (bus.data_data_ok) begin
        n_done++;
        if (n_done == 1) first_done = cyc;
      end
      if (bus.data_addr_ok && bus.data_data_ok) n_both++;
      tick();
      if (n_ok >= 2) bus.data_req = 1'b0;
    end
    bus.arready = 1'b0; bus.rvalid = 1'b0;
    chk("b2b_addr_ok_count", n_ok, 2);
    chk("b2b_data_ok_count", n_done, 2);
    chk("b2b_overlap", n_both, 0);
    chk("b2b_next_accept", second_acc, first_done + 1);

    // Reset while waiting in RD_R, then an immediate new request
    cur_vec = 101;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'b10;
    bus.data_addr = 32'h8000_0010;
    @(negedge clk);
    chk("rr_accept", bus.data_addr_ok, 1'b1);
    tick();
    bus.data_req = 1'b0; bus.arready = 1'b1;
    @(negedge clk);
    chk("rr_arvalid", bus.arvalid, 1'b1);
    tick();
    bus.arready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rr_in_rd_r", bus.rready, 1'b1);
    chk("rr_no_data_ok", bus.data_data_ok, 1'b0);
    tick();
    rst = 1'b0;
    cur_vec = 0;
    do_txn(vecs[0]);

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
